// File: rtl/deaccum_nbits.sv
// Repeated-subtraction decomposer: drains total_i by step_i and reports
// how many whole steps fit (quot_o) and what is left over (rem_o).
module deaccum_nbits #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] total_i,
  input  logic [WIDTH-1:0] step_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH-1:0] rem_o,
  output logic             err_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SUB  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_step;
  logic             r_err;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;

  // Extra MSB of the difference is the borrow: set exactly when rem < step.
  logic [WIDTH:0]   w_diff;
  logic             w_borrow;

  assign w_diff   = {1'b0, r_rem} - {1'b0, r_step};
  assign w_borrow = w_diff[WIDTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_quot  <= '0;
      r_step  <= '0;
      r_err   <= 1'b0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_rem   <= total_i;
            r_step  <= step_i;
            r_quot  <= '0;
            r_err   <= 1'b0;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (r_step == '0) begin
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_state <= S_SUB;
          end
        end
        S_SUB: begin
          if (!w_borrow) begin
            r_rem  <= w_diff[WIDTH-1:0];
            r_quot <= r_quot + WIDTH'(1);
          end else begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ready_o = r_ready;
  assign busy_o  = r_busy;
  assign done_o  = r_done;
  assign quot_o  = r_quot;
  assign rem_o   = r_rem;
  assign err_o   = r_err;

endmodule

// File: tb/tb_deaccum_nbits.sv
// Self-checking bench for deaccum_nbits; expected results come from integer
// division/modulo of the applied operands and the Q+3 latency rule.
module tb_deaccum_nbits;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] total;
  logic [W-1:0] step;
  logic         ready, busy, done, err;
  logic [W-1:0] quot, rem;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  deaccum_nbits #(.WIDTH(W)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .total_i (total),
    .step_i  (step),
    .ready_o (ready),
    .busy_o  (busy),
    .done_o  (done),
    .quot_o  (quot),
    .rem_o   (rem),
    .err_o   (err)
  );

  // Applies one operation from IDLE and checks results, latency and pulse count.
  task automatic run_op(input logic [W-1:0] t, input logic [W-1:0] s, input string name);
    logic [W-1:0] exp_q, exp_r;
    logic         exp_e;
    int           exp_first, first, n_done;
    exp_e     = (s == 0);
    exp_q     = exp_e ? '0 : t / s;
    exp_r     = exp_e ? t : t % s;
    exp_first = exp_e ? 1 : int'(exp_q) + 2;
    first     = -1;
    n_done    = 0;
    @(negedge clk);
    n_vec++;
    if (ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s ready_before_start got=%0b want=1", name, ready);
    end
    start = 1'b1; total = t; step = s;
    @(posedge clk); #1;
    start = 1'b0; total = $urandom; step = $urandom;
    n_vec++;
    if (busy !== 1'b1 || ready !== 1'b0 || quot !== '0 || rem !== t || err !== 1'b0) begin
      n_bad++;
      $display("FAIL %s after_accept got busy=%0b ready=%0b quot=%0d rem=%0d err=%0b want 1 0 0 %0d 0",
               name, busy, ready, quot, rem, err, t);
    end
    for (int k = 1; k <= exp_first + 2; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        n_done++;
        if (first < 0) first = k;
      end
    end
    n_vec++;
    if (n_done != 1 || first != exp_first) begin
      n_bad++;
      $display("FAIL %s done_pulse got count=%0d at_edge=%0d want count=1 at_edge=%0d",
               name, n_done, first, exp_first);
    end
    n_vec++;
    if (quot !== exp_q || rem !== exp_r || err !== exp_e) begin
      n_bad++;
      $display("FAIL %s result got quot=%0d rem=%0d err=%0b want quot=%0d rem=%0d err=%0b",
               name, quot, rem, err, exp_q, exp_r, exp_e);
    end
    n_vec++;
    if (ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s idle_flags got ready=%0b busy=%0b want 1 0", name, ready, busy);
    end
    $display("op %s total=%0d step=%0d -> quot=%0d rem=%0d err=%0b done_edge=%0d",
             name, t, s, quot, rem, err, first);
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1; start = 1'b1; total = 32'd55; step = 32'd5;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0;
    n_vec++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || quot !== '0 || rem !== '0 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state got ready=%0b busy=%0b done=%0b quot=%0d rem=%0d err=%0b want 1 0 0 0 0 0",
               ready, busy, done, quot, rem, err);
    end
    $display("op reset -> ready=%0b quot=%0d rem=%0d", ready, quot, rem);
  endtask

  task automatic test_directed;
    logic [W-1:0] all_ones;
    all_ones = '1;
    run_op(32'd10, 32'd3, "ten_by_three");
    run_op(32'd5,  32'd0, "step_zero");
    run_op(32'd0,  32'd7, "total_zero");
    run_op(32'd4,  32'd9, "step_gt_total");
    run_op(all_ones, all_ones, "max_by_max");
    run_op(all_ones - 1, all_ones, "max_minus_one");
  endtask

  task automatic test_random;
    logic [W-1:0] t, s;
    for (int i = 0; i < 30; i++) begin
      if (i % 2 == 0) begin
        t = W'($urandom_range(0, 300));
        s = W'($urandom_range(0, 25));
      end else begin
        t = $urandom;
        s = t >> $urandom_range(0, 6);
        if ($urandom_range(0, 3) == 0) s = s + W'($urandom_range(1, 9));
      end
      run_op(t, s, $sformatf("rand%0d", i));
    end
  endtask

  task automatic test_reset_abort;
    logic seen;
    seen = 1'b0;
    @(negedge clk);
    start = 1'b1; total = 32'd100; step = 32'd1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen = 1'b1;
      if (k == 4) begin start = 1'b1; total = 32'd7; step = 32'd2; end
      if (k == 5) start = 1'b0;
    end
    n_vec++;
    if (quot !== 32'd19 || rem !== 32'd81) begin
      n_bad++;
      $display("FAIL abort_progress got quot=%0d rem=%0d want quot=19 rem=81", quot, rem);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    if (done === 1'b1) seen = 1'b1;
    n_vec++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || quot !== '0 || rem !== '0 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_reset got ready=%0b busy=%0b done=%0b quot=%0d rem=%0d err=%0b want 1 0 0 0 0 0",
               ready, busy, done, quot, rem, err);
    end
    for (int k = 0; k < 110; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen = 1'b1;
    end
    n_vec++;
    if (seen !== 1'b0 || ready !== 1'b1 || quot !== '0) begin
      n_bad++;
      $display("FAIL abort_no_done got done_seen=%0b ready=%0b quot=%0d want 0 1 0", seen, ready, quot);
    end
    $display("op abort total=100 step=1 reset at cycle 20 -> quot=%0d rem=%0d done_seen=%0b", quot, rem, seen);
  endtask

  task automatic test_back_to_back;
    int first, n_done;
    first = -1; n_done = 0;
    @(negedge clk);
    start = 1'b1; total = 32'd10; step = 32'd3;
    @(posedge clk); #1;
    total = 32'd20; step = 32'd6;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1 && first < 0) first = k;
    end
    n_vec++;
    if (first != 5 || quot !== 32'd3 || rem !== 32'd1) begin
      n_bad++;
      $display("FAIL b2b_first got done_edge=%0d quot=%0d rem=%0d want 5 3 1", first, quot, rem);
    end
    @(posedge clk); #1;
    n_vec++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || quot !== 32'd3 || rem !== 32'd1) begin
      n_bad++;
      $display("FAIL b2b_idle got ready=%0b busy=%0b done=%0b quot=%0d rem=%0d want 1 0 0 3 1",
               ready, busy, done, quot, rem);
    end
    @(posedge clk); #1;
    start = 1'b0;
    n_vec++;
    if (ready !== 1'b0 || busy !== 1'b1 || quot !== '0 || rem !== 32'd20) begin
      n_bad++;
      $display("FAIL b2b_accept got ready=%0b busy=%0b quot=%0d rem=%0d want 0 1 0 20",
               ready, busy, quot, rem);
    end
    first = -1;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        n_done++;
        if (first < 0) first = k;
      end
    end
    n_vec++;
    if (n_done != 1 || first != 5 || quot !== 32'd3 || rem !== 32'd2 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_second got count=%0d done_edge=%0d quot=%0d rem=%0d err=%0b want 1 5 3 2 0",
               n_done, first, quot, rem, err);
    end
    $display("op back_to_back 10/3 then 20/6 -> quot=%0d rem=%0d", quot, rem);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; total = '0; step = '0;
    test_reset();
    test_directed();
    test_random();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
